// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier: FSM states,
// counter sizing and the legal operand-width range.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Ceiling log2, never less than one bit so a WIDTH=2 counter still exists.
  function automatic int cnt_w(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) w++;
    return w;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditionally add (or, for the signed MSB step,
// subtract) the multiplicand into the upper accumulator, then shift the pair right.
module mult_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mplr,
  input  logic             sgn,
  input  logic             last,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] mplr_nxt
);

  logic signed [WIDTH:0] addend;
  logic signed [WIDTH:0] sum;

  always_comb begin
    addend = {sgn & mcand[WIDTH-1], mcand};
    sum    = acc;
    if (mplr[0]) begin
      // Two's-complement MSB carries negative weight, hence the final subtract.
      if (sgn && last) sum = acc - addend;
      else             sum = acc + addend;
    end
    acc_nxt  = {sgn & sum[WIDTH], sum[WIDTH:1]};
    mplr_nxt = {sum[0], mplr[WIDTH-1:1]};
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier with valid/ready handshakes.
// Define MULT_SIGNED_EN to add the signed_mode port for two's-complement operands.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
`ifdef MULT_SIGNED_EN
  ,
  input  logic               signed_mode
`endif
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("shift_add_multiplier: WIDTH must lie in 2..32");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] mplr_nxt;
  logic [WIDTH-1:0] mcand;
  logic             sgn;
  logic             accept;
  logic             last;

  assign accept    = (state == IDLE) && in_valid;
  assign last      = (count == LAST_CNT);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Control: state register and next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  mult_step #(.WIDTH(WIDTH)) u_step (
    .mcand    (mcand),
    .acc      (acc),
    .mplr     (mplr),
    .sgn      (sgn),
    .last     (last),
    .acc_nxt  (acc_nxt),
    .mplr_nxt (mplr_nxt)
  );

  // Datapath: operand capture, iteration and result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= '0;
      mplr    <= '0;
      mcand   <= '0;
      product <= '0;
    end else if (accept) begin
      count <= '0;
      acc   <= '0;
      mplr  <= b;
      mcand <= a;
    end else if (state == RUN) begin
      count <= count + 1'b1;
      acc   <= acc_nxt;
      mplr  <= mplr_nxt;
      if (last) product <= {acc_nxt[WIDTH-1:0], mplr_nxt};
    end
  end

`ifdef MULT_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sgn <= 1'b0;
    else if (accept) sgn <= signed_mode;
  end
`else
  assign sgn = 1'b0;
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised self-checking bench for shift_add_multiplier at WIDTH=4 and WIDTH=8,
// compared against a plain-arithmetic product model.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv4 = 1'b0, or4 = 1'b1;
  logic       ir4, ov4, busy4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;
  bit         mode4 = 1'b0;

  logic        iv8 = 1'b0, or8 = 1'b1;
  logic        ir8, ov8, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .out_valid (ov4),
    .out_ready (or4),
    .product   (p4),
    .busy      (busy4)
`ifdef MULT_SIGNED_EN
    ,
    .signed_mode (mode4)
`endif
  );

  shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .product   (p8),
    .busy      (busy8)
`ifdef MULT_SIGNED_EN
    ,
    .signed_mode (1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Product of two w-bit operands, reduced modulo 2^(2w).
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input bit sm);
    longint sx, sy;
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    sx = longint'({32'd0, x});
    sy = longint'({32'd0, y});
    if (sm) begin
      if (x[w-1]) sx = sx - (longint'(1) << w);
      if (y[w-1]) sy = sy - (longint'(1) << w);
    end
    return 64'(sx * sy) & mask;
  endfunction

  task automatic accept4(input logic [3:0] x, input logic [3:0] y);
    int k;
    logic pre;
    k = 0;
    a4 = x; b4 = y; iv4 = 1'b1;
    do begin
      pre = ir4;
      @(posedge clk); #1;
      k++;
    end while (!pre && k < 40);
    if (!pre) chk("accept4_timeout", 64'd0, 64'd1);
  endtask

  task automatic collect4(input string tag, input logic [7:0] exp, input int stall);
    int k;
    bit ir_bad, hold_bad;
    k = 0; ir_bad = 0; hold_bad = 0;
    if (stall > 0) or4 = 1'b0;
    do begin
      @(posedge clk); #1;
      k++;
      if (ir4) ir_bad = 1;
    end while (!ov4 && k < 40);
    chk({tag, "_lat"}, 64'(k), 64'd4);
    chk({tag, "_prod"}, {56'd0, p4}, {56'd0, exp});
    repeat (stall) begin
      @(posedge clk); #1;
      if (!ov4 || p4 !== exp || ir4) hold_bad = 1;
    end
    if (stall > 0) chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    or4 = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ir_low"}, 64'(ir_bad), 64'd0);
    chk({tag, "_xfer"}, {61'd0, ov4, ir4, busy4}, 64'b010);
    chk({tag, "_keep"}, {56'd0, p4}, {56'd0, exp});
  endtask

  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y);
    int k;
    logic pre;
    logic [63:0] exp;
    exp = ref_mul(8, {24'd0, x}, {24'd0, y}, 1'b0);
    k = 0;
    a8 = x; b8 = y; iv8 = 1'b1;
    do begin
      pre = ir8;
      @(posedge clk); #1;
      k++;
    end while (!pre && k < 40);
    iv8 = 1'b0;
    if (!pre) chk("accept8_timeout", 64'd0, 64'd1);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!ov8 && k < 60);
    chk({tag, "_lat"}, 64'(k), 64'd8);
    chk({tag, "_prod"}, {48'd0, p8}, exp);
    @(posedge clk); #1;
    chk({tag, "_xfer"}, {62'd0, ov8, ir8}, 64'b01);
  endtask

  initial begin
    logic [3:0] ra, rb;
    int st;
    bit rst_bad;

    #12;
    chk("rst_ir4", {63'd0, ir4}, 64'd1);
    chk("rst_ov4", {63'd0, ov4}, 64'd0);
    chk("rst_busy4", {63'd0, busy4}, 64'd0);
    chk("rst_p4", {56'd0, p4}, 64'd0);
    chk("rst_p8", {48'd0, p8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero operands
    accept4(4'd0, 4'd15); iv4 = 1'b0;
    collect4("z0x15", 8'd0, 0);
    accept4(4'd15, 4'd0); iv4 = 1'b0;
    collect4("z15x0", 8'd0, 0);

    // back-to-back with in_valid held high; next operands shown during RUN
    accept4(4'd6, 4'd6); a4 = 4'd2; b4 = 4'd12;
    collect4("b2b_6x6", 8'd36, 0);
    accept4(4'd2, 4'd12); a4 = 4'd9; b4 = 4'd9;
    collect4("b2b_2x12", 8'd24, 0);
    accept4(4'd9, 4'd9); iv4 = 1'b0;
    collect4("b2b_9x9", 8'd81, 0);

    // output backpressure
    accept4(4'd15, 4'd15); iv4 = 1'b0;
    collect4("stall_15x15", 8'hE1, 3);

    // reset in the second RUN cycle
    accept4(4'd10, 4'd5); iv4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; iv4 = 1'b1;
    #3;
    iv4 = 1'b0; rst_n = 1'b1;
    rst_bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov4) rst_bad = 1;
    end
    chk("rst_mid_no_ov", 64'(rst_bad), 64'd0);
    chk("rst_mid_state", {61'd0, ir4, ov4, busy4}, 64'b100);
    chk("rst_mid_p4", {56'd0, p4}, 64'd0);
    accept4(4'd5, 4'd10); iv4 = 1'b0;
    collect4("post_rst_5x10", 8'd50, 0);

`ifdef MULT_SIGNED_EN
    mode4 = 1'b1;
    accept4(4'd15, 4'd15); iv4 = 1'b0;
    collect4("s_m1xm1", 8'd1, 0);
    accept4(4'd8, 4'd7); iv4 = 1'b0;
    collect4("s_m8x7", 8'hC8, 0);
    accept4(4'd7, 4'd8); iv4 = 1'b0;
    collect4("s_7xm8", 8'hC8, 1);
    mode4 = 1'b0;
    accept4(4'd15, 4'd15); iv4 = 1'b0;
    collect4("u_15x15", 8'd225, 0);
    accept4(4'd8, 4'd7); iv4 = 1'b0;
    collect4("u_8x7", 8'd56, 0);
`endif

    // random operand pairs, random stalls
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      st = int'($urandom_range(0, 2));
`ifdef MULT_SIGNED_EN
      mode4 = 1'($urandom);
`endif
      accept4(ra, rb); iv4 = 1'b0;
      collect4($sformatf("rnd4_%0d", i), 8'(ref_mul(4, {28'd0, ra}, {28'd0, rb}, mode4)), st);
    end

    run8("w8_255x255", 8'd255, 8'd255);
    run8("w8_128x2", 8'd128, 8'd2);
    for (int i = 0; i < 6; i++)
      run8($sformatf("rnd8_%0d", i), 8'($urandom), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
